// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch/call/return redirects, a return-address
// stack, stall/halt handling and a one-cycle flush bubble after every redirect.
module pc_sequencer #(
    parameter int ADDR_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b1}}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             halt,
    input  logic                             resume,
    input  logic                             branch,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                target,
    output logic [ADDR_W-1:0]                pc,
    output logic                             fetch_valid,
    output logic                             flush,
    output logic                             halted,
    output logic [$clog2(STACK_DEPTH):0]     depth,
    output logic                             err_ovf,
    output logic                             err_unf
);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam int DW = IW + 1;
    localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

    typedef enum logic [1:0] {START, RUN, FLUSH, HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, push;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_inc;
    logic [IW-1:0]     wr_idx, top_idx;

    assign pc_inc  = pc_q + 1'b1;
    assign wr_idx  = IW'(depth_q);
    assign top_idx = IW'(depth_q - 1'b1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        case (state_q)
            START: begin
                pc_d    = pc_inc;
                state_d = RUN;
            end
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else if (ret) begin
                    if (depth_q != '0) begin
                        pc_d    = stack_q[top_idx];
                        depth_d = depth_q - 1'b1;
                        state_d = FLUSH;
                    end else begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc;
                    end
                end else if (call) begin
                    pc_d    = target;
                    state_d = FLUSH;
                    push    = depth_q != FULL;
                    depth_d = push ? depth_q + 1'b1 : depth_q;
                    ovf_d   = ovf_q | ~push;
                end else if (branch) begin
                    pc_d    = target;
                    state_d = FLUSH;
                end else if (!stall) begin
                    pc_d = pc_inc;
                end
            end
            FLUSH: state_d = RUN;
            default: state_d = (resume && !halt) ? RUN : HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are deliberately not reset; depth alone decides what is readable.
    always_ff @(posedge clk) begin
        if (push && !reset) stack_q[wr_idx] <= pc_inc;
    end

    assign pc          = pc_q;
    assign fetch_valid = state_q == RUN;
    assign flush       = state_q == FLUSH;
    assign halted      = state_q == HALT;
    assign depth       = depth_q;
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan scenarios plus randomized traffic, every cycle
// compared against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset, stall, halt, resume, branch, call, ret;
    logic [7:0] target;
    logic [7:0] pc;
    logic       fetch_valid, flush, halted, err_ovf, err_unf;
    logic [2:0] depth;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
        .branch(branch), .call(call), .ret(ret), .target(target), .pc(pc),
        .fetch_valid(fetch_valid), .flush(flush), .halted(halted), .depth(depth),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_pc = 255;
    bit m_boot = 1, m_bub = 0, m_hlt = 0, m_ovf = 0, m_unf = 0;
    int stk[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_pc = 255; m_boot = 1; m_bub = 0; m_hlt = 0; m_ovf = 0; m_unf = 0;
            stk.delete();
        end else if (m_boot) begin
            m_boot = 0;
            m_pc = (m_pc + 1) % 256;
        end else if (m_bub) begin
            m_bub = 0;
        end else if (m_hlt) begin
            if (resume && !halt) m_hlt = 0;
        end else if (halt) begin
            m_hlt = 1;
        end else if (ret) begin
            if (stk.size() > 0) begin
                m_pc = stk.pop_back();
                m_bub = 1;
            end else begin
                m_unf = 1;
                m_pc = (m_pc + 1) % 256;
            end
        end else if (call) begin
            if (stk.size() < SD) stk.push_back((m_pc + 1) % 256);
            else m_ovf = 1;
            m_pc = int'(target);
            m_bub = 1;
        end else if (branch) begin
            m_pc = int'(target);
            m_bub = 1;
        end else if (!stall) begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("pc", 32'(pc), 32'(m_pc));
        check("fetch_valid", 32'(fetch_valid), 32'(!(m_boot || m_bub || m_hlt)));
        check("flush", 32'(flush), 32'(m_bub));
        check("halted", 32'(halted), 32'(m_hlt));
        check("depth", 32'(depth), 32'(stk.size()));
        check("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check("err_unf", 32'(err_unf), 32'(m_unf));
    endtask

    task automatic idle();
        {reset, stall, halt, resume, branch, call, ret} = '0;
        target = '0;
    endtask

    task automatic restart();
        idle();
        reset = 1; cyc();
        reset = 0; cyc();
    endtask

    int d0;
    int p0;

    initial begin
        idle();
        // Reset release sequence and wrap-around
        reset = 1; cyc();
        check("t1_pc0", 32'(pc), 32'hFF);
        check("t1_fv0", 32'(fetch_valid), 0);
        reset = 0; cyc();
        check("t1_pc1", 32'(pc), 32'h00);
        check("t1_fv1", 32'(fetch_valid), 1);
        cyc(); check("t1_pc2", 32'(pc), 32'h01);
        cyc(); check("t1_pc3", 32'(pc), 32'h02);
        repeat (253) cyc();
        check("t1_pcff", 32'(pc), 32'hFF);
        cyc(); check("t1_wrap", 32'(pc), 32'h00);

        // Branch at 0x05
        repeat (5) cyc();
        check("t2_pre", 32'(pc), 32'h05);
        branch = 1; target = 8'h40; cyc(); idle();
        check("t2_pc", 32'(pc), 32'h40);
        check("t2_flush", 32'(flush), 1);
        check("t2_fv", 32'(fetch_valid), 0);
        cyc(); check("t2_pc_run", 32'(pc), 32'h40); check("t2_fv_run", 32'(fetch_valid), 1);
        cyc(); check("t2_pc_next", 32'(pc), 32'h41);

        // Call at 0x10 then return at 0x83
        restart();
        repeat (16) cyc();
        check("t3_pre", 32'(pc), 32'h10);
        call = 1; target = 8'h80; cyc(); idle(); cyc();
        check("t3_depth", 32'(depth), 1);
        check("t3_pc", 32'(pc), 32'h80);
        repeat (3) cyc();
        check("t3_pre_ret", 32'(pc), 32'h83);
        ret = 1; cyc(); idle(); cyc();
        check("t3_ret_pc", 32'(pc), 32'h11);
        check("t3_ret_depth", 32'(depth), 0);

        // Stack overflow and underflow
        for (int i = 0; i < 5; i++) begin
            call = 1; target = 8'(8'h30 + 8'(i * 16)); cyc(); idle(); cyc();
        end
        check("t4_depth", 32'(depth), 4);
        check("t4_ovf", 32'(err_ovf), 1);
        check("t4_pc", 32'(pc), 32'h70);
        for (int i = 0; i < 4; i++) begin
            ret = 1; cyc(); idle(); cyc();
        end
        p0 = int'(pc);
        ret = 1; cyc(); idle();
        check("t4_unf", 32'(err_unf), 1);
        check("t4_unf_pc", 32'(pc), 32'((p0 + 1) % 256));
        check("t4_unf_flush", 32'(flush), 0);

        // Stall, halt, resume at 0x20
        restart();
        repeat (32) cyc();
        stall = 1; repeat (3) cyc(); idle();
        check("t5_stall_pc", 32'(pc), 32'h20);
        check("t5_stall_fv", 32'(fetch_valid), 1);
        d0 = int'(depth);
        halt = 1; call = 1; target = 8'h99; cyc(); idle();
        check("t5_halted", 32'(halted), 1);
        check("t5_halt_depth", 32'(depth), 32'(d0));
        halt = 1; resume = 1; cyc(); idle();
        check("t5_both_halted", 32'(halted), 1);
        resume = 1; cyc(); idle();
        check("t5_resume_pc", 32'(pc), 32'h20);
        check("t5_resume_fv", 32'(fetch_valid), 1);
        stall = 1; branch = 1; target = 8'h50; cyc(); idle();
        check("t5_sb_pc", 32'(pc), 32'h50);
        check("t5_sb_flush", 32'(flush), 1);

        // Reset in the middle of a flush with depth 2 and errors set
        restart();
        ret = 1; cyc(); idle();
        call = 1; target = 8'h10; cyc(); idle(); cyc();
        call = 1; target = 8'h20; cyc(); idle();
        check("t6_pre_flush", 32'(flush), 1);
        check("t6_pre_depth", 32'(depth), 2);
        reset = 1; cyc(); idle();
        check("t6_pc", 32'(pc), 32'hFF);
        check("t6_depth", 32'(depth), 0);
        check("t6_flush", 32'(flush), 0);
        check("t6_ovf", 32'(err_ovf), 0);
        check("t6_unf", 32'(err_unf), 0);

        // Randomized traffic
        restart();
        for (int i = 0; i < 3000; i++) begin
            reset  = $urandom_range(199) == 0;
            halt   = $urandom_range(99) < 5;
            resume = $urandom_range(99) < 30;
            ret    = $urandom_range(99) < 15;
            call   = $urandom_range(99) < 15;
            branch = $urandom_range(99) < 10;
            stall  = $urandom_range(99) < 20;
            target = 8'($urandom_range(255));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
